// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared definitions for the pipeline sequencer. Holds the state
//               encodings, the per-stage control bundle, the bubble-select
//               constant and helpers that build the control bundle for each
//               operating case.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Encodings are fixed so the pipeline registers and hazard unit can decode
  // the sequencer state directly.
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DWAIT = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Value of a *_flush strobe that makes a pipeline register load a bubble.
  localparam logic BUBBLE_SEL = 1'b1;

  typedef struct packed {
    logic pc_en;
    logic pc_redirect;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } ctrl_t;

  // Boot / in-reset: nothing loads, every register holds a bubble.
  localparam ctrl_t CTRL_BOOT = ctrl_t'(9'b0_0_0000_111);
  // Free-running pipeline: every stage advances, nothing flushed.
  localparam ctrl_t CTRL_PASS = ctrl_t'(9'b1_0_1111_000);
  // Halted: everything holds, no bubbles injected.
  localparam ctrl_t CTRL_HALT = ctrl_t'(9'b0_0_0000_000);

  // Data-memory wait: freeze the front of the pipe, keep retiring into WB
  // with a bubble so the stalled MEM instruction is not written back twice.
  function automatic ctrl_t ctrl_freeze();
    ctrl_t c;
    c             = CTRL_PASS;
    c.pc_en       = 1'b0;
    c.ifid_en     = 1'b0;
    c.idex_en     = 1'b0;
    c.exmem_en    = 1'b0;
    c.memwb_flush = BUBBLE_SEL;
    return c;
  endfunction

  // Normal operation, highest priority first.
  function automatic ctrl_t ctrl_run(input logic hz_stall,
                                     input logic ex_brtaken,
                                     input logic imem_ready,
                                     input logic mem_wait);
    ctrl_t c;
    c = CTRL_PASS;
    if (mem_wait) begin
      c = ctrl_freeze();
    end else if (ex_brtaken) begin
      c.pc_redirect = 1'b1;
      c.ifid_flush  = BUBBLE_SEL;
      c.idex_flush  = BUBBLE_SEL;
    end else if (hz_stall) begin
      c.pc_en      = 1'b0;
      c.ifid_en    = 1'b0;
      c.idex_flush = BUBBLE_SEL;
    end else if (!imem_ready) begin
      c.pc_en      = 1'b0;
      c.ifid_flush = BUBBLE_SEL;
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Bundle between the pipeline sequencer and the core.
//               slave  - the sequencer (consumes hazard/memory status,
//                        produces enables, flushes, status and counters)
//               master - the core side driving the status inputs
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  // status into the sequencer
  logic             hz_stall;
  logic             ex_brtaken;
  logic             imem_ready;
  logic             mem_dreq;
  logic             dmem_ready;
  logic             wb_halt;
  // controls out of the sequencer
  logic             pc_en;
  logic             pc_redirect;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             memwb_flush;
  logic             halted;
  logic             err_timeout;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output hz_stall, ex_brtaken, imem_ready, mem_dreq, dmem_ready, wb_halt,
    input  pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, memwb_flush, halted, err_timeout,
    input  cyc_cnt, stall_cnt
  );

  modport slave (
    input  hz_stall, ex_brtaken, imem_ready, mem_dreq, dmem_ready, wb_halt,
    output pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, memwb_flush, halted, err_timeout,
    output cyc_cnt, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : perf_cnt
// Description : Free-running performance counter, wraps modulo 2^W.
// Ports       : clk   - clock
//               rst_n - synchronous active-low clear
//               inc   - count this cycle
//               cnt   - current count
// Revision    : 1.0 - initial release
// ============================================================================
module perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline sequencer for the 5-stage core. Converts hazard,
//               branch, memory-ready and halt status into per-stage register
//               enables, bubble strobes and the PC redirect select. Owns the
//               boot flush, the dmem wait watchdog, halt state and the
//               cycle / stall performance counters.
// Ports       : clk   - clock, all state on rising edge
//               rst_n - synchronous active-low reset
//               bus   - pipe_ctrl_if.slave (status in, controls/counters out)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DWAIT_MAX = 255,
  parameter int DW_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic [DW_W-1:0]  r_dwait_cnt;
  logic             r_err_timeout;
  ctrl_t            w_ctrl;
  logic             w_halted;
  logic             w_timeout;
  logic             w_active;
  logic             w_stall_inc;
  logic [CNT_W-1:0] w_cyc_cnt;
  logic [CNT_W-1:0] w_stall_cnt;

  always_comb begin
    w_ctrl       = CTRL_BOOT;
    w_halted     = 1'b0;
    w_timeout    = 1'b0;
    w_next_state = r_state;
    case (r_state)
      ST_INIT: begin
        w_next_state = ST_RUN;
      end
      ST_RUN: begin
        w_ctrl = ctrl_run(bus.hz_stall, bus.ex_brtaken, bus.imem_ready,
                          bus.mem_dreq && !bus.dmem_ready);
        if (bus.mem_dreq && !bus.dmem_ready) begin
          w_next_state = ST_DWAIT;
        end
      end
      ST_DWAIT: begin
        if (bus.dmem_ready) begin
          // Completion cycle: the frozen branch/stall inputs act now.
          w_ctrl       = ctrl_run(bus.hz_stall, bus.ex_brtaken, bus.imem_ready, 1'b0);
          w_next_state = ST_RUN;
        end else begin
          w_ctrl = ctrl_freeze();
          if (r_dwait_cnt == DW_W'(DWAIT_MAX - 1)) begin
            w_timeout    = !bus.wb_halt;
            w_next_state = ST_HALT;
          end
        end
      end
      default: begin
        w_ctrl   = CTRL_HALT;
        w_halted = 1'b1;
      end
    endcase

    // The retiring halt instruction still completes WB this cycle.
    if ((r_state == ST_RUN || r_state == ST_DWAIT) && bus.wb_halt) begin
      w_next_state = ST_HALT;
    end

    if (!rst_n) begin
      w_ctrl   = CTRL_BOOT;
      w_halted = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_INIT;
      r_dwait_cnt   <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Count only consecutive DWAIT cycles; any exit restarts the watchdog.
      if (r_state == ST_DWAIT && w_next_state == ST_DWAIT) begin
        r_dwait_cnt <= r_dwait_cnt + DW_W'(1);
      end else begin
        r_dwait_cnt <= '0;
      end
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  assign w_active    = rst_n && (r_state == ST_RUN || r_state == ST_DWAIT);
  assign w_stall_inc = w_active && !w_ctrl.pc_en && !w_ctrl.pc_redirect;

  perf_cnt #(.W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_active),
    .cnt   (w_cyc_cnt)
  );

  perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .cnt   (w_stall_cnt)
  );

  assign bus.pc_en       = w_ctrl.pc_en;
  assign bus.pc_redirect = w_ctrl.pc_redirect;
  assign bus.ifid_en     = w_ctrl.ifid_en;
  assign bus.idex_en     = w_ctrl.idex_en;
  assign bus.exmem_en    = w_ctrl.exmem_en;
  assign bus.memwb_en    = w_ctrl.memwb_en;
  assign bus.ifid_flush  = w_ctrl.ifid_flush;
  assign bus.idex_flush  = w_ctrl.idex_flush;
  assign bus.memwb_flush = w_ctrl.memwb_flush;
  assign bus.halted      = w_halted;
  assign bus.err_timeout = r_err_timeout;
  assign bus.cyc_cnt     = w_cyc_cnt;
  assign bus.stall_cnt   = w_stall_cnt;

endmodule
`default_nettype wire
